// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 pipeline hazard logic: forward-select codes and the
// in-flight destination entry tracked between EX and WB.
package mips_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_AW   = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } entry_t;

endpackage

// File: rtl/mips_hazard_scoreboard_if.sv
// ID-to-hazard-unit bundle: decoded instruction in, accept/forward decision and counters out.
interface mips_hazard_scoreboard_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);

  logic              issue_valid;
  logic [REG_AW-1:0] issue_rs;
  logic [REG_AW-1:0] issue_rt;
  logic              issue_rs_used;
  logic              issue_rt_used;
  logic [REG_AW-1:0] issue_rd;
  logic              issue_wr;
  logic              issue_is_load;
  logic              flush;
  logic              issue_ready;
  logic [1:0]        fwd_sel_rs;
  logic [1:0]        fwd_sel_rt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  fwd_cnt;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used,
    output issue_rd, issue_wr, issue_is_load, flush,
    input  issue_ready, fwd_sel_rs, fwd_sel_rt, stall_cnt, fwd_cnt
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used,
    input  issue_rd, issue_wr, issue_is_load, flush,
    output issue_ready, fwd_sel_rs, fwd_sel_rt, stall_cnt, fwd_cnt
  );

endinterface

// File: rtl/mips_src_match.sv
// Per-operand hazard decision: finds the youngest in-flight producer of one source register
// and turns its stage into a stall request or a forward select.
module mips_src_match
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned PIPE_DEPTH = 3,
  parameter bit          FWD_EN     = 1'b1
) (
  input  logic [REG_AW-1:0]         src,
  input  logic                      used,
  input  entry_t [PIPE_DEPTH-1:0]   ents,
  output logic                      stall,
  output fwd_sel_e                  sel
);

  logic found;

  // The WB entry is excluded: the register file writes before it reads.
  always_comb begin
    stall = 1'b0;
    sel   = FWD_RF;
    found = 1'b0;
    for (int k = 0; k < int'(PIPE_DEPTH) - 1; k++) begin
      if (!found && used && (src != '0) && ents[k].valid && (ents[k].rd == src)) begin
        found = 1'b1;
        if (!FWD_EN) begin
          stall = 1'b1;
        end else if (k == 0) begin
          if (ents[k].is_load) stall = 1'b1;
          else                 sel   = FWD_EXMEM;
        end else if (k == 1) begin
          sel = FWD_MEMWB;
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mips_hazard_scoreboard.sv
// Issue-stage hazard unit: shifts destination entries from EX to WB and decides per issuing
// instruction whether to stall, forward, or read the register file.
module mips_hazard_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned NUM_REGS   = mips_pkg::NUM_REGS,
  parameter int unsigned REG_AW     = mips_pkg::REG_AW,
  parameter int unsigned PIPE_DEPTH = 3,
  parameter bit          FWD_EN     = 1'b1,
  parameter int unsigned CNT_W      = 32
) (
  input logic                     clk1,
  input logic                     rst,
  mips_hazard_scoreboard_if.slave bus
);

  if ((REG_AW != $clog2(NUM_REGS)) || (REG_AW != mips_pkg::REG_AW) ||
      (PIPE_DEPTH < 2) || (PIPE_DEPTH > 8)) begin : g_bad_cfg
    $error("mips_hazard_scoreboard: unsupported NUM_REGS/REG_AW/PIPE_DEPTH");
  end

  entry_t [PIPE_DEPTH-1:0] e_q;
  logic                    stall_rs, stall_rt;
  fwd_sel_e                sel_rs, sel_rt;
  logic                    ready, accept, fwd_any, stall_evt;
  logic [CNT_W-1:0]        stall_cnt_q, fwd_cnt_q;

  mips_src_match #(
    .REG_AW    (REG_AW),
    .PIPE_DEPTH(PIPE_DEPTH),
    .FWD_EN    (FWD_EN)
  ) u_match_rs (
    .src  (bus.issue_rs),
    .used (bus.issue_rs_used),
    .ents (e_q),
    .stall(stall_rs),
    .sel  (sel_rs)
  );

  mips_src_match #(
    .REG_AW    (REG_AW),
    .PIPE_DEPTH(PIPE_DEPTH),
    .FWD_EN    (FWD_EN)
  ) u_match_rt (
    .src  (bus.issue_rt),
    .used (bus.issue_rt_used),
    .ents (e_q),
    .stall(stall_rt),
    .sel  (sel_rt)
  );

  assign ready     = ~bus.flush & ~stall_rs & ~stall_rt;
  assign accept    = bus.issue_valid & ready & bus.issue_wr & (bus.issue_rd != '0);
  assign fwd_any   = (sel_rs != FWD_RF) | (sel_rt != FWD_RF);
  assign stall_evt = bus.issue_valid & ~ready & ~bus.flush;

  assign bus.issue_ready = ready;
  assign bus.fwd_sel_rs  = ready ? sel_rs : FWD_RF;
  assign bus.fwd_sel_rt  = ready ? sel_rt : FWD_RF;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.fwd_cnt     = fwd_cnt_q;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      e_q         <= '0;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      e_q[0].valid   <= accept;
      e_q[0].rd      <= accept ? bus.issue_rd : '0;
      e_q[0].is_load <= accept & bus.issue_is_load;
      for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
        e_q[k] <= e_q[k-1];
        // A taken branch kills the instruction leaving EX.
        if ((k == 1) && bus.flush) e_q[k].valid <= 1'b0;
      end
      if (stall_evt && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (bus.issue_valid && ready && fwd_any && !(&fwd_cnt_q)) begin
        fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
